// File: rtl/apb_timer_pkg.sv
// Shared register map and field positions for the APB timer slave and its bench.
package apb_timer_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_LOAD    = 3'd1;
  localparam logic [2:0] REG_VALUE   = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_SCRATCH = 3'd4;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int CTRL_W         = 3;
  localparam int STATUS_EXPIRED = 0;

  function automatic logic [31:0] reg_offset(input logic [2:0] idx);
    return {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_timer_counter.sv
// Down-counter holding VALUE: decrement, reload on expiry, and direct load from a LOAD write.
module apb_timer_counter
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             load_wr,
  input  logic [CNT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_reg,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // A LOAD write takes priority over any count activity on the same edge.
  always_comb begin
    value_d = value_q;
    if (load_wr) begin
      value_d = load_data;
    end else if (en) begin
      if (value_q != '0) begin
        value_d = value_q - CNT_W'(1);
      end else if (auto_reload) begin
        value_d = load_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign expire = en && (value_q == '0);

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB slave: register decode, CTRL/LOAD/STATUS/SCRATCH, registered read data, irq.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int SEL_BIT = 0,
  parameter int CNT_W   = 32
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  logic              sel;
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        idx;
  logic              wr_ctrl;
  logic              wr_load;
  logic              wr_status;
  logic              wr_scratch;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  load_q;
  logic              expired_q;
  logic [31:0]       scratch_q;
  logic [31:0]       prdata_q;
  logic [31:0]       rdata;
  logic [CNT_W-1:0]  value;
  logic              expire;
  logic              unused_bits;

  assign sel        = psel[SEL_BIT];
  assign idx        = paddr[4:2];
  assign wr_en      = sel && penable && pwrite;
  assign rd_en      = sel && !penable && !pwrite;
  assign wr_ctrl    = wr_en && (idx == REG_CTRL);
  assign wr_load    = wr_en && (idx == REG_LOAD);
  assign wr_status  = wr_en && (idx == REG_STATUS);
  assign wr_scratch = wr_en && (idx == REG_SCRATCH);

  assign unused_bits = &{1'b0, psel, paddr[31:5], paddr[1:0]};

  apb_timer_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk        (hclk),
    .rst_n      (hresetn),
    .en         (ctrl_q[CTRL_EN]),
    .auto_reload(ctrl_q[CTRL_AUTO]),
    .load_wr    (wr_load),
    .load_data  (pwdata[CNT_W-1:0]),
    .load_reg   (load_q),
    .value      (value),
    .expire     (expire)
  );

  // A CTRL write on the expiry edge overrides the one-shot clear of EN.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= pwdata[CTRL_W-1:0];
    end else if (expire && !ctrl_q[CTRL_AUTO]) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      load_q <= '0;
    end else if (wr_load) begin
      load_q <= pwdata[CNT_W-1:0];
    end
  end

  // A fresh expiry beats a write-one-to-clear on the same edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      expired_q <= 1'b0;
    end else if (expire) begin
      expired_q <= 1'b1;
    end else if (wr_status && pwdata[STATUS_EXPIRED]) begin
      expired_q <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      scratch_q <= '0;
    end else if (wr_scratch) begin
      scratch_q <= pwdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:    rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_LOAD:    rdata = 32'(load_q);
      REG_VALUE:   rdata = 32'(value);
      REG_STATUS:  rdata = {31'd0, expired_q};
      REG_SCRATCH: rdata = scratch_q;
      default:     rdata = '0;
    endcase
  end

  // Read data is captured in the setup phase and held through the access phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      prdata_q <= '0;
    end else if (rd_en) begin
      prdata_q <= rdata;
    end
  end

  assign prdata = prdata_q;
  assign irq    = expired_q && ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave; read expectations travel through a scoreboard queue.
module tb_apb_timer_slave;
  import apb_timer_pkg::*;

  localparam logic [2:0] SEL = 3'b001;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  apb_timer_slave #(
    .SEL_BIT(0),
    .CNT_W  (32)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .irq    (irq)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] s, input logic [31:0] addr, input logic [31:0] data);
    psel    = s;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = addr;
    pwdata  = data;
    @(posedge hclk);
    #1 penable = 1'b1;
    @(posedge hclk);
    #1 bus_idle();
  endtask

  task automatic apb_read(input logic [2:0] s, input logic [31:0] addr,
                          input logic [31:0] exp, input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    psel    = s;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = addr;
    @(posedge hclk);
    #1 penable = 1'b1;
    @(posedge hclk);
    #1 bus_idle();
    e = sb_q.pop_front();
    chk(e.tag, prdata, e.exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hresetn = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    bus_idle();
    #3;
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    // Every offset reads zero out of reset
    for (int i = 0; i < 8; i++) begin
      apb_read(SEL, reg_offset(3'(i)), 32'd0, $sformatf("t1_read_off%0d", i));
    end
    chk("t1_irq", {31'd0, irq}, 32'd0);

    // Auto-reload: LOAD=5 gives a 6-cycle period
    apb_write(SEL, reg_offset(REG_LOAD), 32'd5);
    apb_write(SEL, reg_offset(REG_CTRL), 32'h7);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t2_irq_pre%0d", i), {31'd0, irq}, 32'd0);
    end
    tick();
    chk("t2_irq_expire1", {31'd0, irq}, 32'd1);
    apb_write(SEL, reg_offset(REG_STATUS), 32'h1);
    chk("t2_irq_cleared", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_irq_gap%0d", i), {31'd0, irq}, 32'd0);
    end
    tick();
    chk("t2_irq_expire2", {31'd0, irq}, 32'd1);
    apb_read(SEL, reg_offset(REG_VALUE), 32'd5, "t2_value_reloaded");
    apb_write(SEL, reg_offset(REG_CTRL), 32'h0);

    // One-shot stops itself at zero
    apb_write(SEL, reg_offset(REG_STATUS), 32'h1);
    apb_write(SEL, reg_offset(REG_LOAD), 32'd3);
    apb_write(SEL, reg_offset(REG_CTRL), 32'h1);
    repeat (8) tick();
    apb_read(SEL, reg_offset(REG_CTRL), 32'h0, "t3_ctrl");
    apb_read(SEL, reg_offset(REG_VALUE), 32'h0, "t3_value");
    apb_read(SEL, reg_offset(REG_STATUS), 32'h1, "t3_status");
    chk("t3_irq", {31'd0, irq}, 32'd0);

    // W1C, and W1C colliding with an expiry
    apb_write(SEL, reg_offset(REG_CTRL), 32'h4);
    chk("t4_irq_on", {31'd0, irq}, 32'd1);
    apb_write(SEL, reg_offset(REG_STATUS), 32'h1);
    chk("t4_irq_off", {31'd0, irq}, 32'd0);
    apb_read(SEL, reg_offset(REG_STATUS), 32'h0, "t4_status_cleared");
    apb_write(SEL, reg_offset(REG_LOAD), 32'd0);
    apb_write(SEL, reg_offset(REG_CTRL), 32'h3);
    apb_write(SEL, reg_offset(REG_STATUS), 32'h1);
    apb_read(SEL, reg_offset(REG_STATUS), 32'h1, "t4_status_set_wins");
    apb_write(SEL, reg_offset(REG_CTRL), 32'h0);
    apb_write(SEL, reg_offset(REG_STATUS), 32'h1);
    apb_read(SEL, reg_offset(REG_STATUS), 32'h0, "t4_status_idle_clear");

    // Unmapped/read-only writes, scratch, foreign psel
    apb_write(SEL, reg_offset(REG_LOAD), 32'd7);
    apb_write(SEL, 32'h0000_001C, 32'hDEAD_BEEF);
    apb_read(SEL, 32'h0000_001C, 32'h0, "t5_unmapped");
    apb_write(SEL, reg_offset(REG_VALUE), 32'hDEAD_BEEF);
    apb_read(SEL, reg_offset(REG_VALUE), 32'd7, "t5_value_ro");
    apb_write(SEL, reg_offset(REG_SCRATCH), 32'hA5A5_5A5A);
    apb_read(SEL, reg_offset(REG_SCRATCH), 32'hA5A5_5A5A, "t5_scratch");
    apb_write(3'b010, reg_offset(REG_SCRATCH), 32'h1234_5678);
    apb_write(3'b100, reg_offset(REG_LOAD), 32'h55);
    apb_read(3'b100, reg_offset(REG_CTRL), 32'hA5A5_5A5A, "t5_prdata_hold");
    apb_read(SEL, reg_offset(REG_SCRATCH), 32'hA5A5_5A5A, "t5_scratch_foreign");
    apb_read(SEL, reg_offset(REG_LOAD), 32'd7, "t5_load_foreign");
    apb_read(SEL, reg_offset(REG_VALUE), 32'd7, "t5_value_foreign");

    // Asynchronous reset mid-count and mid-access
    apb_write(SEL, reg_offset(REG_LOAD), 32'd2);
    apb_write(SEL, reg_offset(REG_CTRL), 32'h5);
    repeat (5) tick();
    chk("t6_irq_armed", {31'd0, irq}, 32'd1);
    apb_write(SEL, reg_offset(REG_LOAD), 32'd100);
    apb_write(SEL, reg_offset(REG_CTRL), 32'h5);
    apb_read(SEL, reg_offset(REG_SCRATCH), 32'hA5A5_5A5A, "t6_scratch_pre");
    repeat (3) tick();
    psel    = SEL;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = reg_offset(REG_VALUE);
    @(posedge hclk);
    #1 penable = 1'b1;
    #2 hresetn = 1'b0;
    #1;
    chk("t6_prdata_async", prdata, 32'd0);
    chk("t6_irq_async", {31'd0, irq}, 32'd0);
    bus_idle();
    tick();
    chk("t6_prdata_held", prdata, 32'd0);
    hresetn = 1'b1;
    apb_read(SEL, reg_offset(REG_CTRL), 32'h0, "t6_ctrl");
    apb_read(SEL, reg_offset(REG_LOAD), 32'h0, "t6_load");
    apb_read(SEL, reg_offset(REG_VALUE), 32'h0, "t6_value");
    apb_read(SEL, reg_offset(REG_STATUS), 32'h0, "t6_status");
    apb_read(SEL, reg_offset(REG_SCRATCH), 32'h0, "t6_scratch");
    chk("t6_irq_after", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
